// File: rtl/fifo_rr_scheduler_pkg.sv
// rtl/fifo_rr_scheduler_pkg.sv - shared widths, entry layout and arbiter constants
package fifo_rr_scheduler_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int NREQ_DEF   = 4;
  localparam int IDW_DEF    = $clog2(NREQ_DEF);
  localparam int RR_PTR_RST = 0;

  function automatic int entry_width(input int width, input int idw);
    return width + idw;
  endfunction

  // FIFO entry as stored: source tag above payload
  typedef struct packed {
    logic [IDW_DEF-1:0]   src;
    logic [WIDTH_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// rtl/fifo_rr_scheduler_rr_arbiter.sv - rotating-priority one-hot arbiter
module rr_arbiter
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gidx;
  logic           found;
  int             idx;

  // First set request at or above ptr, wrapping modulo NREQ
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (enable) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          gidx     = IDW'(idx);
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDW'(RR_PTR_RST);
    end else if (found) begin
      ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin push sharing and valid/ready pop for an external FIFO
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int IDW    = $clog2(NREQ),
  parameter int CNTWID = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NREQ-1:0]                     req,
  input  logic [NREQ*WIDTH-1:0]               req_data,
  output logic [NREQ-1:0]                     gnt,
  output logic                                fifo_push,
  output logic [entry_width(WIDTH,IDW)-1:0]   fifo_data_in,
  output logic                                fifo_pop,
  input  logic                                fifo_empty,
  input  logic                                fifo_full,
  input  logic [entry_width(WIDTH,IDW)-1:0]   fifo_data_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    out_data,
  output logic [IDW-1:0]                      out_src,
  output logic [CNTWID-1:0]                   occupancy,
  output logic                                err
);

  logic           can_push;
  logic [IDW-1:0] gnt_idx;

  assign out_valid          = (occupancy != '0) & ~rst;
  assign fifo_pop           = out_valid & out_ready;
  assign {out_src, out_data} = fifo_data_out;

  // A pop this cycle frees a slot, so a full FIFO can still accept a push
  assign can_push = (occupancy < CNTWID'(DEPTH)) | fifo_pop;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (can_push & ~rst),
    .req    (req),
    .gnt    (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = IDW'(i);
    end
  end

  assign fifo_push    = |gnt;
  assign fifo_data_in = {gnt_idx, req_data[gnt_idx*WIDTH +: WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNTWID'(fifo_push) - CNTWID'(fifo_pop);
    end
  end

  // Shadow count and FIFO flags update on the same edge, so compare current values
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (((occupancy == '0) != fifo_empty) ||
                 ((occupancy == CNTWID'(DEPTH)) != fifo_full)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb/tb_fifo_rr_scheduler.sv - bench for fifo_rr_scheduler with a behavioural shift-register FIFO
module tb_fifo_rr_scheduler;
  import fifo_rr_scheduler_pkg::*;

  localparam int NREQ = 4, WIDTH = 8, DEPTH = 8, IDW = 2, CNTWID = 4, EW = WIDTH + IDW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [EW-1:0]         fifo_data_in, fifo_data_out;
  logic                  out_valid, out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_src;
  logic [CNTWID-1:0]     occupancy;
  logic                  err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_push(fifo_push), .fifo_data_in(fifo_data_in), .fifo_pop(fifo_pop),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_data_out(fifo_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .occupancy(occupancy), .err(err)
  );

  // Attached FIFO: head at mem[0], zero-latency read
  logic [EW-1:0] mem [DEPTH];
  int            cnt;
  logic          force_ne;

  assign fifo_empty    = force_ne ? 1'b0 : (cnt == 0);
  assign fifo_full     = (cnt == DEPTH);
  assign fifo_data_out = mem[0];

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
    end else begin
      if (fifo_pop) for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      if (fifo_push && (cnt - (fifo_pop ? 1 : 0)) < DEPTH) mem[cnt - (fifo_pop ? 1 : 0)] <= fifo_data_in;
      cnt <= cnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
    end
  end

  entry_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; inputs return to idle just after the edge
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input logic rdy,
                      input logic [NREQ-1:0] eg, input logic ep, input string tag);
    entry_t e;
    int gi;
    @(negedge clk);
    req = r; req_data = d; out_ready = rdy;
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".push"}, 32'(fifo_push), 32'(|eg));
    chk({tag, ".pop"}, 32'(fifo_pop), 32'(ep));
    if (ep) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL %s.sb: got pop expected no entry", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, ".src"}, 32'(out_src), 32'(e.src));
        chk({tag, ".data"}, 32'(out_data), 32'(e.data));
      end
    end
    if (eg != 0) begin
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (eg[i]) gi = i;
      e.src  = IDW'(gi);
      e.data = d[gi*WIDTH +: WIDTH];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req = '0; out_ready = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0] r;
    logic            rdy;
    logic [NREQ-1:0] eg;
    logic            ep;
    logic [CNTWID-1:0] occ;
  } vec_t;

  vec_t v[9];
  logic [NREQ*WIDTH-1:0] d;

  initial begin
    v[0] = '{4'b1111, 1'b0, 4'b0001, 1'b0, 4'd1};
    v[1] = '{4'b1111, 1'b0, 4'b0010, 1'b0, 4'd2};
    v[2] = '{4'b1111, 1'b0, 4'b0100, 1'b0, 4'd3};
    v[3] = '{4'b1111, 1'b0, 4'b1000, 1'b0, 4'd4};
    v[4] = '{4'b1111, 1'b0, 4'b0001, 1'b0, 4'd5};
    v[5] = '{4'b1111, 1'b0, 4'b0010, 1'b0, 4'd6};
    v[6] = '{4'b1111, 1'b0, 4'b0100, 1'b0, 4'd7};
    v[7] = '{4'b1111, 1'b0, 4'b1000, 1'b0, 4'd8};
    v[8] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 4'd8};

    rst = 1'b1; req = '0; req_data = '0; out_ready = 1'b0; force_ne = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt", 32'(gnt), 0);
    chk("rst.valid", 32'(out_valid), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle.occ", 32'(occupancy), 0);
    chk("idle.err", 32'(err), 0);
    chk("idle.valid", 32'(out_valid), 0);

    // Round-robin fill to full
    for (int j = 0; j < 9; j++) begin
      for (int l = 0; l < NREQ; l++) d[l*WIDTH +: WIDTH] = 8'(16 * j + l + 1);
      step(v[j].r, d, v[j].rdy, v[j].eg, v[j].ep, $sformatf("rr%0d", j));
      chk($sformatf("rr%0d.occ", j), 32'(occupancy), 32'(v[j].occ));
    end
    chk("full.flag", 32'(fifo_full), 1);
    chk("full.err", 32'(err), 0);

    // Push into full FIFO alongside a pop
    step(4'b0100, {8'h00, 8'hC2, 8'h00, 8'h00}, 1'b1, 4'b0100, 1'b1, "fullpp");
    chk("fullpp.occ", 32'(occupancy), 8);
    for (int j = 0; j < 8; j++) step('0, '0, 1'b1, '0, 1'b1, $sformatf("drain%0d", j));
    chk("drain.occ", 32'(occupancy), 0);
    chk("drain.valid", 32'(out_valid), 0);

    // Tag/data ordering; pointer currently 3
    step(4'b0010, {8'h00, 8'h00, 8'hA5, 8'h00}, 1'b0, 4'b0010, 1'b0, "tag1");
    step(4'b1000, {8'h3C, 8'h00, 8'h00, 8'h00}, 1'b0, 4'b1000, 1'b0, "tag3");
    step('0, '0, 1'b1, '0, 1'b1, "tagpop1");
    step('0, '0, 1'b1, '0, 1'b1, "tagpop2");
    chk("tag.valid", 32'(out_valid), 0);
    chk("tag.occ", 32'(occupancy), 0);

    // Pointer skip: grant 0 leaves ptr=1, then 1001 -> 3, then 1001 -> 0
    step(4'b0001, {8'h00, 8'h00, 8'h00, 8'h11}, 1'b0, 4'b0001, 1'b0, "skip0");
    step(4'b1001, {8'h77, 8'h00, 8'h00, 8'h22}, 1'b0, 4'b1000, 1'b0, "skip1");
    step(4'b1001, {8'h77, 8'h00, 8'h00, 8'h22}, 1'b0, 4'b0001, 1'b0, "skip2");
    for (int j = 0; j < 3; j++) step('0, '0, 1'b1, '0, 1'b1, $sformatf("skipdr%0d", j));
    chk("skip.occ", 32'(occupancy), 0);

    // Flag mismatch sets sticky err
    @(negedge clk); force_ne = 1'b1;
    @(posedge clk); #1; force_ne = 1'b0;
    chk("err.set", 32'(err), 1);
    @(posedge clk); #1;
    chk("err.sticky", 32'(err), 1);

    for (int j = 0; j < 5; j++) step(4'b0001, 32'h55, 1'b0, 4'b0001, 1'b0, $sformatf("pre%0d", j));
    chk("pre.occ", 32'(occupancy), 5);

    // Mid-operation reset
    @(negedge clk); rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
    #1;
    chk("mrst.gnt", 32'(gnt), 0);
    chk("mrst.push", 32'(fifo_push), 0);
    chk("mrst.pop", 32'(fifo_pop), 0);
    chk("mrst.valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = '0; out_ready = 1'b0;
    chk("mrst.occ", 32'(occupancy), 0);
    chk("mrst.err", 32'(err), 0);
    sb.delete();
    step(4'b1111, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b0, 4'b0001, 1'b0, "mrst.ptr");
    step('0, '0, 1'b1, '0, 1'b1, "mrst.pop1");
    chk("end.err", 32'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
